// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Includes the FSM encoding, forward-select codes and the register-match helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_e;

    typedef logic [4:0] reg_idx_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // $zero is never a real producer, so a write to r0 must not create a dependency.
    function automatic logic reg_hit(input logic wr_en, input reg_idx_t dst, input reg_idx_t src);
        return wr_en && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-state inputs and control outputs exchanged between datapath and hazard_ctrl.
// The datapath side uses the master modport and the controller uses the slave modport.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs_d, rt_d, rs_e, rt_e;
    logic [4:0]       write_reg_e, write_reg_m, write_reg_w;
    logic             reg_write_e, reg_write_m, reg_write_w;
    logic             mem_to_reg_e, mem_to_reg_m;
    logic             mem_req_m, mem_ready;
    logic             branch_d, pc_src_d;

    logic             forward_a_d, forward_b_d;
    logic [1:0]       forward_a_e, forward_b_e;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_w;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs_d, rt_d, rs_e, rt_e,
        output write_reg_e, write_reg_m, write_reg_w,
        output reg_write_e, reg_write_m, reg_write_w,
        output mem_to_reg_e, mem_to_reg_m,
        output mem_req_m, mem_ready, branch_d, pc_src_d,
        input  forward_a_d, forward_b_d, forward_a_e, forward_b_e,
        input  stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, flush_w, halt, stall_cnt
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e,
        input  write_reg_e, write_reg_m, write_reg_w,
        input  reg_write_e, reg_write_m, reg_write_w,
        input  mem_to_reg_e, mem_to_reg_m,
        input  mem_req_m, mem_ready, branch_d, pc_src_d,
        output forward_a_d, forward_b_d, forward_a_e, forward_b_e,
        output stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, flush_w, halt, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// Purely combinational forwarding selects for the EX ALU operands and the ID branch comparator.
// The MEM-stage producer is younger than the WB one, so it takes priority.
module forward_unit
    import hazard_ctrl_pkg::*;
(
    input  reg_idx_t   rs_d,
    input  reg_idx_t   rt_d,
    input  reg_idx_t   rs_e,
    input  reg_idx_t   rt_e,
    input  reg_idx_t   write_reg_m,
    input  reg_idx_t   write_reg_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic       forward_a_d,
    output logic       forward_b_d,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e
);

    function automatic logic [1:0] ex_sel(input reg_idx_t src, input logic wm, input reg_idx_t dm,
                                          input logic ww, input reg_idx_t dw);
        if (reg_hit(wm, dm, src))      return FWD_M;
        else if (reg_hit(ww, dw, src)) return FWD_W;
        else                           return FWD_REG;
    endfunction

    assign forward_a_e = ex_sel(rs_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    assign forward_b_e = ex_sel(rt_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);

    // Only ALUOutM can reach the ID comparator; WB values arrive via the register file.
    assign forward_a_d = reg_hit(reg_write_m, write_reg_m, rs_d);
    assign forward_b_d = reg_hit(reg_write_m, write_reg_m, rt_d);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: forwarding, load-use and branch
// stalls, and a supervised multi-cycle data-memory wait sequence with a sticky halt.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave hz
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   stall_cnt_q;

    logic       fwd_a_d, fwd_b_d;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       lw_stall, br_stall, mem_stall;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w, halt;

    forward_unit u_fwd (
        .rs_d        (hz.rs_d),
        .rt_d        (hz.rt_d),
        .rs_e        (hz.rs_e),
        .rt_e        (hz.rt_e),
        .write_reg_m (hz.write_reg_m),
        .write_reg_w (hz.write_reg_w),
        .reg_write_m (hz.reg_write_m),
        .reg_write_w (hz.reg_write_w),
        .forward_a_d (fwd_a_d),
        .forward_b_d (fwd_b_d),
        .forward_a_e (fwd_a_e),
        .forward_b_e (fwd_b_e)
    );

    assign lw_stall = hz.mem_to_reg_e && (hz.rt_e != '0) &&
                      ((hz.rt_e == hz.rs_d) || (hz.rt_e == hz.rt_d));

    assign br_stall = hz.branch_d &&
                      (reg_hit(hz.reg_write_e,  hz.write_reg_e, hz.rs_d) ||
                       reg_hit(hz.reg_write_e,  hz.write_reg_e, hz.rt_d) ||
                       reg_hit(hz.mem_to_reg_m, hz.write_reg_m, hz.rs_d) ||
                       reg_hit(hz.mem_to_reg_m, hz.write_reg_m, hz.rt_d));

    assign mem_stall = ((state_q == RUN) && hz.mem_req_m && !hz.mem_ready) ||
                       ((state_q == MEM_WAIT) && !hz.mem_ready);

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            RUN: begin
                wait_d = '0;
                if (mem_stall) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                wait_d = wait_q + WCNT_W'(1);
                // A completion on the final permitted cycle still counts as success.
                if (hz.mem_ready)                                state_d = RUN;
                else if (wait_q == WCNT_W'(WAIT_MAX - 1))        state_d = TIMEOUT;
            end
            TIMEOUT: state_d = TIMEOUT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        halt    = 1'b0;
        if (!rst_n) begin
            // outputs stay quiet while reset is held
        end else if (state_q == TIMEOUT) begin
            halt    = 1'b1;
            {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
            flush_w = 1'b1;
        end else if (mem_stall) begin
            // Full freeze; pending lw/branch stalls are re-evaluated once memory releases.
            {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
            flush_w = 1'b1;
        end else if (lw_stall || br_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            flush_d = hz.pc_src_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (stall_f && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign hz.forward_a_d = rst_n & fwd_a_d;
    assign hz.forward_b_d = rst_n & fwd_b_d;
    assign hz.forward_a_e = rst_n ? fwd_a_e : FWD_REG;
    assign hz.forward_b_e = rst_n ? fwd_b_e : FWD_REG;
    assign hz.stall_f     = stall_f;
    assign hz.stall_d     = stall_d;
    assign hz.stall_e     = stall_e;
    assign hz.stall_m     = stall_m;
    assign hz.flush_d     = flush_d;
    assign hz.flush_e     = flush_e;
    assign hz.flush_w     = flush_w;
    assign hz.halt        = halt;
    assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs into a queue,
// and a monitor on the falling edge pops and compares against the DUT.
module tb_hazard_ctrl;

    localparam int CNT_W    = 3;
    localparam int WAIT_MAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       rw_e, rw_m, rw_w, mtr_e, mtr_m;
        logic       mem_req, mem_ready, branch, pc_src;
    } in_t;

    typedef struct packed {
        logic             fa_d, fb_d;
        logic [1:0]       fa_e, fb_e;
        logic             sf, sd, se, sm;
        logic             fd, fe, fw, halt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        string name;
        exp_t  e;
    } sb_t;

    sb_t              sb_q[$];
    int               tests = 0;
    int               fails = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    function automatic in_t idle();
        in_t i;
        i = '0;
        i.rst_n = 1'b1;
        return i;
    endfunction

    function automatic exp_t none();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t freeze();
        exp_t e;
        e = '0;
        {e.sf, e.sd, e.se, e.sm, e.fw} = 5'b11111;
        return e;
    endfunction

    function automatic exp_t hold();
        exp_t e;
        e = '0;
        {e.sf, e.sd, e.fe} = 3'b111;
        return e;
    endfunction

    task automatic drive(input in_t i);
        rst_n           = i.rst_n;
        hz.rs_d         = i.rs_d;
        hz.rt_d         = i.rt_d;
        hz.rs_e         = i.rs_e;
        hz.rt_e         = i.rt_e;
        hz.write_reg_e  = i.wr_e;
        hz.write_reg_m  = i.wr_m;
        hz.write_reg_w  = i.wr_w;
        hz.reg_write_e  = i.rw_e;
        hz.reg_write_m  = i.rw_m;
        hz.reg_write_w  = i.rw_w;
        hz.mem_to_reg_e = i.mtr_e;
        hz.mem_to_reg_m = i.mtr_m;
        hz.mem_req_m    = i.mem_req;
        hz.mem_ready    = i.mem_ready;
        hz.branch_d     = i.branch;
        hz.pc_src_d     = i.pc_src;
    endtask

    // One cycle of stimulus; stall_cnt expectation comes from a saturating count of expected stall_f.
    task automatic apply(input string name, input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        drive(i);
        e.cnt = model_cnt;
        sb_q.push_back('{name, e});
        if (!i.rst_n)                          model_cnt = '0;
        else if (e.sf && (model_cnt != '1))    model_cnt = model_cnt + 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t  s;
            exp_t act;
            s = sb_q.pop_front();
            act.fa_d = hz.forward_a_d;  act.fb_d = hz.forward_b_d;
            act.fa_e = hz.forward_a_e;  act.fb_e = hz.forward_b_e;
            act.sf   = hz.stall_f;      act.sd   = hz.stall_d;
            act.se   = hz.stall_e;      act.sm   = hz.stall_m;
            act.fd   = hz.flush_d;      act.fe   = hz.flush_e;
            act.fw   = hz.flush_w;      act.halt = hz.halt;
            act.cnt  = hz.stall_cnt;
            tests++;
            if (act !== s.e) begin
                fails++;
                $display("FAIL %s: got %b expected %b (fa_d fb_d fa_e fb_e sf sd se sm fd fe fw halt cnt)",
                         s.name, act, s.e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t  i;
        exp_t e;

        i = idle();
        i.rst_n = 1'b0;
        drive(i);
        repeat (2) @(posedge clk);

        apply("reset", i, none());
        apply("idle", idle(), none());

        // Forwarding priority
        i = idle(); i.rw_m = 1; i.wr_m = 8; i.rs_e = 8; i.rw_w = 1; i.wr_w = 8;
        e = none(); e.fa_e = 2'b10;
        apply("fwd_m_wins", i, e);
        i.wr_m = 0;
        e = none(); e.fa_e = 2'b01;
        apply("fwd_w_when_m_r0", i, e);
        i = idle(); i.rs_e = 8; i.rt_e = 3; i.rw_m = 1; i.wr_m = 8; i.rw_w = 1; i.wr_w = 3;
        e = none(); e.fa_e = 2'b10; e.fb_e = 2'b01;
        apply("fwd_a_m_b_w", i, e);

        // Load-use
        i = idle(); i.mtr_e = 1; i.rt_e = 9; i.rs_d = 9;
        apply("lw_use", i, hold());
        i = idle(); i.mtr_m = 1; i.rw_m = 1; i.wr_m = 9; i.rs_d = 9; i.mem_req = 1; i.mem_ready = 1;
        e = none(); e.fa_d = 1;
        apply("lw_in_m_single_cycle", i, e);
        i = idle(); i.mtr_e = 1; i.rt_e = 0;
        apply("lw_rt_zero", i, none());

        // Branch hazards
        i = idle(); i.branch = 1; i.rs_d = 5; i.rw_e = 1; i.wr_e = 5;
        apply("br_hazard_e", i, hold());
        i = idle(); i.branch = 1; i.rs_d = 5; i.rw_m = 1; i.wr_m = 5; i.pc_src = 1;
        e = none(); e.fa_d = 1; e.fd = 1;
        apply("br_fwd_m_taken", i, e);
        i = idle(); i.branch = 1; i.rt_d = 6; i.mtr_m = 1; i.rw_m = 1; i.wr_m = 6;
        i.mem_req = 1; i.mem_ready = 1;
        e = hold(); e.fb_d = 1;
        apply("br_load_in_m", i, e);

        // Multi-cycle memory access
        i = idle(); i.mem_req = 1;
        apply("mw_run", i, freeze());
        apply("mw_wait0", i, freeze());
        apply("mw_wait1", i, freeze());
        i.mem_ready = 1;
        apply("mw_ready", i, none());
        apply("mw_done", idle(), none());

        // Load-use coincident with memory wait
        i = idle(); i.mem_req = 1; i.mtr_e = 1; i.rt_e = 9; i.rs_d = 9;
        apply("lw_and_mem", i, freeze());
        i.mem_ready = 1;
        apply("lw_after_ready", i, hold());
        apply("cnt_saturated", idle(), none());

        // Timeout and sticky halt
        i = idle(); i.mem_req = 1;
        apply("to_run", i, freeze());
        for (int k = 0; k < WAIT_MAX; k++) apply($sformatf("to_wait%0d", k), i, freeze());
        e = freeze(); e.halt = 1;
        apply("to_halt", i, e);
        i = idle(); i.mem_ready = 1; i.pc_src = 1;
        apply("to_sticky", i, e);
        i = idle(); i.rst_n = 0; i.rw_m = 1; i.wr_m = 8; i.rs_e = 8; i.mem_req = 1;
        apply("to_reset_held", i, none());
        apply("post_reset", idle(), none());
        i = idle(); i.rw_m = 1; i.wr_m = 8; i.rs_e = 8;
        e = none(); e.fa_e = 2'b10;
        apply("post_reset_fwd", i, e);

        // Ready on the final permitted wait cycle returns to RUN
        i = idle(); i.mem_req = 1;
        apply("last_run", i, freeze());
        for (int k = 0; k < WAIT_MAX - 1; k++) apply($sformatf("last_wait%0d", k), i, freeze());
        i.mem_ready = 1;
        apply("last_ready_wins", i, none());
        apply("last_back_in_run", idle(), none());

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
